// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Brief    : Shared types, constants and helpers for the systolic array blocks.
// Revision : 1.0
// ============================================================================
package tpu_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } acc_state_e;

  localparam int ACC_DATA_W = 32;

  // Signed overflow of a two's-complement add, judged from the sign bits only.
  function automatic logic sadd_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_bank
// Brief    : DEPTH-entry store/accumulate bank, drained over valid/ready.
// Revision : 1.0
// ============================================================================
module accumulator_bank
  import tpu_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              full,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  acc_state_e        state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_sum;
  logic [DATA_W-1:0] wr_val;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wr_old   = mem_q[wr_ptr_q];
  assign wr_sum   = wr_old + in_data;
  assign wr_val   = in_mode ? wr_sum : in_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Drained entries are zeroed so the next pass may start in accumulate mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (in_fire && (wr_ptr_q == IDX_W'(i))) begin
          mem_q[i] <= wr_val;
        end else if (out_fire && (rd_ptr_q == IDX_W'(i))) begin
          mem_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (in_fire) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      if ((wr_ptr_q == LAST_IDX) && in_last) state_d = DRAIN;
      if (in_mode && sadd_ovf(wr_old[DATA_W-1], in_data[DATA_W-1], wr_sum[DATA_W-1])) begin
        overflow_d = 1'b1;
      end
    end
    if (out_fire) begin
      if (rd_ptr_q == LAST_IDX) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        state_d  = FILL;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DRAIN);
    full      = (state_q == DRAIN);
    out_index = rd_ptr_q;
    out_data  = (state_q == DRAIN) ? mem_q[rd_ptr_q] : '0;
    overflow  = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_bank
// Brief    : Directed plus randomized bench for accumulator_bank with a reference model.
// Revision : 1.0
// ============================================================================
module tb_accumulator_bank;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              full;
  logic              overflow;

  accumulator_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: entry contents, fill position, drain flag, sticky overflow.
  logic [31:0] m_mem [DEPTH];
  int          m_wr;
  bit          m_drain;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_wr = 0; m_drain = 0; m_ovf = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_full"},      32'(full),      32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_out_index"}, 32'(out_index), 32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic beat(input logic [31:0] d, input bit mode, input bit last);
    longint s;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = mode; in_last = last;
    #1;
    chk("fill_in_ready", 32'(in_ready), 32'd1);
    chk("fill_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (mode) begin
      s = longint'($signed(m_mem[m_wr])) + longint'($signed(d));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
      m_mem[m_wr] = s[31:0];
    end else begin
      m_mem[m_wr] = d;
    end
    if (m_wr == DEPTH - 1) begin
      m_wr = 0;
      if (last) m_drain = 1;
    end else begin
      m_wr++;
    end
    chk("fill_full", 32'(full), 32'(m_drain));
    chk("fill_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  // Drain every entry; stall_idx holds out_ready low for 3 cycles on that entry.
  task automatic drain(input int stall_idx, input bit rnd);
    int k = 0;
    int stall = 0;
    int budget = 0;
    while (k < DEPTH) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == stall_idx && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_mode  = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      #1;
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      chk("drain_out_index", 32'(out_index), 32'(k));
      chk("drain_out_data",  out_data,       m_mem[k]);
      chk("drain_in_ready",  32'(in_ready),  32'd0);
      chk("drain_full",      32'(full),      32'd1);
      chk("drain_overflow",  32'(overflow),  32'(m_ovf));
      @(posedge clk);
      #1;
      if (out_ready) begin
        m_mem[k] = '0;
        k++;
      end
      budget++;
      if (budget > 200) begin
        checks++;
        failures++;
        $error("FAIL drain_timeout observed=%0d expected=%0d", k, DEPTH);
        break;
      end
    end
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    m_drain = 0; m_wr = 0;
    check_idle("post_drain");
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = $urandom; in_mode = 1'b0; in_last = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    check_idle("post_clear");
  endtask

  initial begin
    int np;
    bit fin;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_idle("reset");

    // Store pass 5,0,7,9.
    beat(32'd5, 0, 0); beat(32'd0, 0, 0); beat(32'd7, 0, 0); beat(32'd9, 0, 1);
    drain(-1, 0);

    // Store then accumulate, then accumulate-only onto zeroed entries.
    beat(32'd1, 0, 0);  beat(32'd2, 0, 0);  beat(32'd3, 0, 0);  beat(32'd4, 0, 0);
    beat(32'd10, 1, 0); beat(32'd20, 1, 0); beat(32'd30, 1, 0); beat(32'd40, 1, 1);
    drain(-1, 0);
    for (int i = 0; i < DEPTH; i++) beat(32'd1, 1, i == DEPTH - 1);
    drain(-1, 0);

    // Signed overflow stays sticky through the drain and clears on clear.
    beat(32'h7FFF_FFFF, 0, 0); beat(32'd1, 0, 0); beat(32'd2, 0, 0); beat(32'd3, 0, 0);
    beat(32'd1, 1, 0); beat(32'd1, 1, 0); beat(32'd1, 1, 0); beat(32'd1, 1, 1);
    chk("ovf_set", 32'(overflow), 32'd1);
    drain(-1, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_clear();

    // Back-pressure on entry 2 while input beats are offered during the drain.
    for (int i = 0; i < DEPTH; i++) beat($urandom, 0, i == DEPTH - 1);
    drain(2, 0);

    // in_last on entry 1 must not end the pass.
    beat(32'd11, 0, 0); beat(32'd12, 0, 1);
    chk("early_last_full", 32'(full), 32'd0);
    beat(32'd13, 0, 1); beat(32'd14, 0, 1);
    drain(-1, 0);

    // clear mid-fill restarts the write pointer and zeroes entries.
    beat(32'd100, 0, 0); beat(32'd200, 0, 0);
    do_clear();
    for (int i = 0; i < DEPTH; i++) beat(32'(i + 1), 1, i == DEPTH - 1);
    drain(-1, 0);

    // Randomized multi-pass traffic with random back-pressure.
    for (int p = 0; p < 6; p++) begin
      np = $urandom_range(1, 3);
      for (int q = 0; q < np; q++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if ($urandom_range(0, 3) == 0) idle_cycle();
          fin = (q == np - 1) && (e == DEPTH - 1);
          beat($urandom, 1'($urandom_range(0, 1)),
               (e == DEPTH - 1) ? fin : 1'($urandom_range(0, 1)));
        end
      end
      drain(-1, 1);
    end
    do_clear();

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < DEPTH; i++) beat(32'(50 + i), 0, i == DEPTH - 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pre_reset_index", 32'(out_index), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_idle("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) beat(32'(i + 7), 1, i == DEPTH - 1);
    drain(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
